// File: rtl/alu_muldiv_seq_if.sv
// -----------------------------------------------------------------------------
// alu_muldiv_seq_if
//   Bundle of the request/result and shared-ALU signals of alu_muldiv_seq.
//
//   Request side : start, op (0=MULU, 1=DIVU), a, b
//   Status side  : busy, done
//   Result side  : hi, lo
//   ALU side     : alu_req, alu_ctr, alu_a, alu_b (to the shared ALU mux),
//                  alu_result (combinational result of the shared ALU)
//
//   modport slave  : the sequencer itself
//   modport master : the surrounding core (request source + shared ALU)
// -----------------------------------------------------------------------------
interface alu_muldiv_seq_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             alu_req;
  logic [2:0]       alu_ctr;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;

  modport slave (
    input  start, op, a, b, alu_result,
    output busy, done, hi, lo, alu_req, alu_ctr, alu_a, alu_b
  );

  modport master (
    output start, op, a, b, alu_result,
    input  busy, done, hi, lo, alu_req, alu_ctr, alu_a, alu_b
  );

endinterface

// File: rtl/alu_muldiv_seq.sv
// -----------------------------------------------------------------------------
// alu_muldiv_seq
//   Multi-cycle unsigned multiply/divide sequencer that borrows the shared ALU.
//   Every step issues exactly one ALU operation (ADD, SUB or SLTU); shifts are
//   done on local registers. MULU leaves {hi,lo} = a*b, DIVU leaves
//   lo = quotient, hi = remainder. Divide by zero gives lo = all-ones, hi = a.
//
//   Ports
//     CLK    : clock, rising edge
//     Reset  : synchronous, active-high; drops any operation in flight
//     bus    : alu_muldiv_seq_if.slave
//              start/op/a/b in, busy/done/hi/lo out,
//              alu_req/alu_ctr/alu_a/alu_b out, alu_result in
//
//   Timing: an operation accepted in IDLE reaches DONE on the 2*WIDTH-th edge
//   after the accept edge; done is high for that one DONE cycle.
// -----------------------------------------------------------------------------
module alu_muldiv_seq #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [2:0]  CTR_ADD  = 3'b000,
  parameter logic [2:0]  CTR_SUB  = 3'b001,
  parameter logic [2:0]  CTR_SLTU = 3'b101
) (
  input  logic            CLK,
  input  logic            Reset,
  alu_muldiv_seq_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    M_ADD,
    M_CRY,
    D_CMP,
    D_SUB,
    DONE
  } stateType;

  stateType         state;
  stateType         nextState;

  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;
  logic [WIDTH-1:0] operandReg;   // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] sumReg;       // partial sum from M_ADD
  logic [WIDTH-1:0] addendReg;    // addend used in M_ADD, needed for the carry
  logic [WIDTH-1:0] rsReg;        // shifted partial remainder from D_CMP
  logic             msbReg;       // bit shifted out of hi in D_CMP
  logic             ltReg;        // rs < divisor from D_CMP
  logic [CNT_W-1:0] iterCount;

  logic             aluReq;
  logic [2:0]       aluCtr;
  logic [WIDTH-1:0] aluA;
  logic [WIDTH-1:0] aluB;

  logic [WIDTH-1:0] remShift;
  logic             lastIter;
  logic             divZero;

  // Partial remainder shifted left by one with the next dividend bit.
  assign remShift = {hiReg[WIDTH-2:0], loReg[WIDTH-1]};
  assign lastIter = (iterCount == CNT_W'(WIDTH - 1));
  assign divZero  = (bus.b == '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  // ---------------------------------------------------------------------------
  // Next state and ALU request
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    nextState = state;
    aluReq    = 1'b0;
    aluCtr    = 3'b000;
    aluA      = '0;
    aluB      = '0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (!bus.op)     nextState = M_ADD;
          else if (divZero) nextState = DONE;
          else             nextState = D_CMP;
        end
      end

      M_ADD: begin
        aluReq    = 1'b1;
        aluCtr    = CTR_ADD;
        aluA      = hiReg;
        aluB      = loReg[0] ? operandReg : '0;
        nextState = M_CRY;
      end

      // Unsigned overflow of sum = hi + addend shows up as sum < addend.
      M_CRY: begin
        aluReq    = 1'b1;
        aluCtr    = CTR_SLTU;
        aluA      = sumReg;
        aluB      = addendReg;
        nextState = lastIter ? DONE : M_ADD;
      end

      D_CMP: begin
        aluReq    = 1'b1;
        aluCtr    = CTR_SLTU;
        aluA      = remShift;
        aluB      = operandReg;
        nextState = D_SUB;
      end

      D_SUB: begin
        aluReq    = 1'b1;
        aluCtr    = CTR_SUB;
        aluA      = rsReg;
        aluB      = operandReg;
        nextState = lastIter ? DONE : D_CMP;
      end

      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (Reset) begin
      hiReg      <= '0;
      loReg      <= '0;
      operandReg <= '0;
      sumReg     <= '0;
      addendReg  <= '0;
      rsReg      <= '0;
      msbReg     <= 1'b0;
      ltReg      <= 1'b0;
      iterCount  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            iterCount  <= '0;
            operandReg <= bus.b;
            if (bus.op && divZero) begin
              hiReg <= bus.a;
              loReg <= '1;
            end else begin
              hiReg <= '0;
              loReg <= bus.a;
            end
          end
        end

        M_ADD: begin
          sumReg    <= bus.alu_result;
          addendReg <= aluB;
        end

        // Shift {carry, sum, lo} right by one: the product grows into hi
        // while consumed multiplier bits fall off the bottom of lo.
        M_CRY: begin
          hiReg     <= {bus.alu_result[0], sumReg[WIDTH-1:1]};
          loReg     <= {sumReg[0], loReg[WIDTH-1:1]};
          iterCount <= iterCount + CNT_W'(1);
        end

        D_CMP: begin
          rsReg  <= remShift;
          msbReg <= hiReg[WIDTH-1];
          ltReg  <= bus.alu_result[0];
          loReg  <= {loReg[WIDTH-2:0], 1'b0};
        end

        // A set msb means the true partial remainder is 2^W + rs, which always
        // exceeds the divisor; the modulo-2^W difference is still exact.
        D_SUB: begin
          if (msbReg || !ltReg) begin
            hiReg    <= bus.alu_result;
            loReg[0] <= 1'b1;
          end else begin
            hiReg    <= rsReg;
          end
          iterCount <= iterCount + CNT_W'(1);
        end

        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.hi      = hiReg;
  assign bus.lo      = loReg;
  assign bus.alu_req = aluReq;
  assign bus.alu_ctr = aluCtr;
  assign bus.alu_a   = aluA;
  assign bus.alu_b   = aluB;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_muldiv_seq
//   Self-checking bench for alu_muldiv_seq. Provides the shared ALU as a
//   combinational model, drives directed corner cases and randomized MULU/DIVU
//   requests, and compares latency, ALU usage and hi/lo against a reference
//   computed with plain 64-bit multiply, divide and modulo.
// -----------------------------------------------------------------------------
module tb_alu_muldiv_seq;

  localparam int unsigned W        = 32;
  localparam logic [2:0]  CTR_ADD  = 3'b000;
  localparam logic [2:0]  CTR_SUB  = 3'b001;
  localparam logic [2:0]  CTR_SLTU = 3'b101;

  logic CLK;
  logic Reset;

  int checkCount = 0;
  int errorCount = 0;

  alu_muldiv_seq_if #(.WIDTH(W)) bus ();

  alu_muldiv_seq #(
    .WIDTH   (W),
    .CTR_ADD (CTR_ADD),
    .CTR_SUB (CTR_SUB),
    .CTR_SLTU(CTR_SLTU)
  ) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Shared ALU model.
  always_comb begin
    bus.alu_result = '0;
    case (bus.alu_ctr)
      CTR_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
      CTR_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
      CTR_SLTU: bus.alu_result = {{(W-1){1'b0}}, (bus.alu_a < bus.alu_b)};
      default:  bus.alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands.
  function automatic void refModel(input logic isDiv, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] eHi, output logic [W-1:0] eLo,
                                   output int eLat, output int eReq);
    logic [63:0] prod;
    if (!isDiv) begin
      prod = {32'b0, x} * {32'b0, y};
      eHi  = prod[63:32];
      eLo  = prod[31:0];
      eLat = 2 * W + 1;
      eReq = 2 * W;
    end else if (y == 0) begin
      eHi  = x;
      eLo  = '1;
      eLat = 1;
      eReq = 0;
    end else begin
      eLo  = x / y;
      eHi  = x % y;
      eLat = 2 * W + 1;
      eReq = 2 * W;
    end
  endfunction

  // Runs one operation. Entered and left at a negedge. The latency counts
  // rising edges from the accept edge (inclusive) until done is observed.
  task automatic runOp(input logic isDiv, input logic [W-1:0] x, input logic [W-1:0] y,
                       input string tag, input bit noise);
    logic [W-1:0] eHi, eLo;
    int eLat, eReq;
    int edges, reqCycles, badIdle, badCtr;
    refModel(isDiv, x, y, eHi, eLo, eLat, eReq);
    reqCycles = 0;
    badIdle   = 0;
    badCtr    = 0;

    bus.start = 1'b1;
    bus.op    = isDiv;
    bus.a     = x;
    bus.b     = y;
    @(posedge CLK);
    edges = 1;
    @(negedge CLK);
    bus.start = 1'b0;
    bus.op    = 1'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
    check($sformatf("%s.busyAfterAccept", tag), bus.busy, 1);

    while (!bus.done && edges < 300) begin
      if (bus.alu_req) begin
        reqCycles++;
        if (bus.alu_ctr != CTR_ADD && bus.alu_ctr != CTR_SUB && bus.alu_ctr != CTR_SLTU) badCtr++;
      end else if (bus.alu_ctr != 3'b000 || bus.alu_a != '0 || bus.alu_b != '0) begin
        badIdle++;
      end
      if (noise) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.op    = 1'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
      end
      @(posedge CLK);
      edges++;
      @(negedge CLK);
    end

    check($sformatf("%s.doneSeen", tag), bus.done, 1);
    check($sformatf("%s.latency", tag), edges, eLat);
    check($sformatf("%s.aluReqCycles", tag), reqCycles, eReq);
    check($sformatf("%s.aluIdleNonZero", tag), badIdle, 0);
    check($sformatf("%s.aluBadCtr", tag), badCtr, 0);
    check($sformatf("%s.hi", tag), bus.hi, eHi);
    check($sformatf("%s.lo", tag), bus.lo, eLo);
    check($sformatf("%s.busyInDone", tag), bus.busy, 1);
    check($sformatf("%s.aluReqInDone", tag), bus.alu_req, 0);

    // A start in the DONE cycle must be ignored.
    bus.start = 1'b1;
    bus.op    = 1'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
    @(posedge CLK);
    @(negedge CLK);
    bus.start = 1'b0;
    check($sformatf("%s.donePulse", tag), bus.done, 0);
    check($sformatf("%s.idleBusy", tag), bus.busy, 0);
    check($sformatf("%s.hiHold", tag), bus.hi, eHi);
    check($sformatf("%s.loHold", tag), bus.lo, eLo);
  endtask

  // Reset in the middle of a multiply at iteration 20.
  task automatic resetMidOp();
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'h1357_9BDF;
    bus.b     = 32'h2468_ACE0;
    @(posedge CLK);
    @(negedge CLK);
    bus.start = 1'b0;
    repeat (39) @(posedge CLK);
    @(negedge CLK);
    check("midReset.busyBefore", bus.busy, 1);
    Reset = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    check("midReset.busy", bus.busy, 0);
    check("midReset.done", bus.done, 0);
    check("midReset.hi", bus.hi, 0);
    check("midReset.lo", bus.lo, 0);
    check("midReset.aluReq", bus.alu_req, 0);
  endtask

  logic         rIsDiv;
  logic [W-1:0] rA, rB;

  initial begin
    Reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset.busy", bus.busy, 0);
    check("reset.done", bus.done, 0);
    check("reset.hi", bus.hi, 0);
    check("reset.lo", bus.lo, 0);
    check("reset.aluReq", bus.alu_req, 0);
    check("reset.aluCtr", bus.alu_ctr, 0);
    Reset = 1'b0;
    @(negedge CLK);

    runOp(1'b0, 32'd3,          32'd5,          "mul3x5",    1'b0);
    runOp(1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  "mulMax",    1'b0);
    runOp(1'b1, 32'd100,        32'd7,          "div100by7", 1'b0);
    runOp(1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  "divMaxMax", 1'b0);
    runOp(1'b1, 32'h8000_0000,  32'd1,          "divBy1",    1'b0);
    runOp(1'b1, 32'hFFFF_FFFF,  32'h8000_0001,  "divMsb",    1'b0);
    runOp(1'b1, 32'h0000_1234,  32'd0,          "divZero",   1'b0);
    runOp(1'b0, 32'hDEAD_BEEF,  32'h1234_5678,  "mulNoise",  1'b1);
    runOp(1'b1, 32'hCAFE_F00D,  32'h0000_0F0F,  "divNoise",  1'b1);

    resetMidOp();
    runOp(1'b0, 32'd6, 32'd7, "mul6x7", 1'b0);

    for (int i = 0; i < 40; i++) begin
      rIsDiv = 1'($urandom_range(0, 1));
      rA     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      case ($urandom_range(0, 7))
        0:       rB = '0;
        1:       rB = 32'($urandom_range(1, 15));
        2:       rB = '1;
        default: rB = $urandom;
      endcase
      runOp(rIsDiv, rA, rB, $sformatf("rand%0d", i), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
